mem2hexserial: RTL and testbench



---
 rtl/mem2hexserial_pkg.sv | 22 ++
 rtl/hex_nibble_ascii.sv | 21 ++
 rtl/mem2hexserial.sv | 145 ++++++++++++++
 tb/tb_mem2hexserial.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem2hexserial_pkg.sv
// rtl/mem2hexserial_pkg.sv - shared states, ASCII constants and index sizing for mem2hexserial
package mem2hexserial_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;
    localparam logic [7:0] SP   = 8'h20;
    localparam logic [7:0] ZERO = 8'h30;

    // Bits needed to count 0 .. n-1 bytes within one line (at least 1).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// rtl/hex_nibble_ascii.sv - combinational 4-bit value to ASCII hex digit encoder
module hex_nibble_ascii
    import mem2hexserial_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    // 0-9 offset from '0'; 10-15 offset so that 10 lands on 'A' or 'a'.
    always_comb begin
        o_ascii = ZERO;
        if (i_nibble < 4'd10) begin
            o_ascii = ZERO + {4'h0, i_nibble};
        end else begin
            o_ascii = (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, i_nibble};
        end
    end

endmodule

// File: rtl/mem2hexserial.sv
// rtl/mem2hexserial.sv - renders ring buffer records as ASCII hex lines for uart_tx (optional MEM2HEXSERIAL_SEQ_EN line prefix)
module mem2hexserial
    import mem2hexserial_pkg::*;
#(
    parameter int DW        = 48,
    parameter bit UPPERCASE = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          read_empty,
    output logic          read_clock_enable,
    input  logic [DW-1:0] read_data,
    input  logic          uart_ready,
    output logic          uart_clock_enable,
    output logic [7:0]    uart_data
);

    localparam int NDIG = DW / 4;
`ifdef MEM2HEXSERIAL_SEQ_EN
    localparam int PRE = 3;
`else
    localparam int PRE = 0;
`endif
    localparam int LINE_LEN = PRE + NDIG + 2;
    localparam int IW       = idx_width(LINE_LEN);

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_idx;
    logic [DW-1:0]   r_shift;
    logic [7:0]      r_uart_data;
    logic [3:0]      w_nibble;
    logic [7:0]      w_hex;
    logic [7:0]      w_byte;
    logic            w_last;
    logic            w_strobe;

`ifdef MEM2HEXSERIAL_SEQ_EN
    logic [7:0]      r_seq;
`endif

    assign w_last   = (r_idx == IW'(LINE_LEN - 1));
    assign w_strobe = (r_state == SEND) && uart_ready;

    assign read_clock_enable = (r_state == POP);
    assign uart_clock_enable = w_strobe;
    // Present the new byte in its strobe cycle, otherwise hold the last one sent.
    assign uart_data         = w_strobe ? w_byte : r_uart_data;

    // Choose which nibble feeds the encoder: sequence digits first, then the record MSB-first.
    always_comb begin
        w_nibble = r_shift[DW-1 -: 4];
`ifdef MEM2HEXSERIAL_SEQ_EN
        if (r_idx == IW'(0)) begin
            w_nibble = r_seq[7:4];
        end else if (r_idx == IW'(1)) begin
            w_nibble = r_seq[3:0];
        end
`endif
    end

    hex_nibble_ascii #(
        .UPPERCASE (UPPERCASE)
    ) u_hex (
        .i_nibble (w_nibble),
        .o_ascii  (w_hex)
    );

    // Select the byte at the current line position: hex digit, separator, CR or LF.
    always_comb begin
        w_byte = w_hex;
        if (r_idx == IW'(LINE_LEN - 2)) begin
            w_byte = CR;
        end else if (r_idx == IW'(LINE_LEN - 1)) begin
            w_byte = LF;
        end
`ifdef MEM2HEXSERIAL_SEQ_EN
        else if (r_idx == IW'(2)) begin
            w_byte = SP;
        end
`endif
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: one record in flight, HOLD masks uart_tx's ready deassert latency.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!read_empty) w_next = POP;
            POP:     w_next = LATCH;
            LATCH:   w_next = SEND;
            SEND:    if (uart_ready) w_next = HOLD;
            HOLD:    w_next = w_last ? IDLE : SEND;
            default: w_next = IDLE;
        endcase
    end

    // Record shift register, byte index and last-sent byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx       <= '0;
            r_shift     <= '0;
            r_uart_data <= 8'h00;
        end else begin
            if (r_state == LATCH) begin
                r_shift <= read_data;
                r_idx   <= '0;
            end else if (r_state == HOLD) begin
                if (!w_last) begin
                    r_idx <= r_idx + IW'(1);
                end
`ifdef MEM2HEXSERIAL_SEQ_EN
                if (r_idx >= IW'(PRE)) begin
                    r_shift <= {r_shift[DW-5:0], 4'h0};
                end
`else
                r_shift <= {r_shift[DW-5:0], 4'h0};
`endif
            end
            if (w_strobe) begin
                r_uart_data <= w_byte;
            end
        end
    end

`ifdef MEM2HEXSERIAL_SEQ_EN
    // Line sequence number advances once the LF has gone out, wrapping at 0xFF.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_seq <= 8'h00;
        end else if ((r_state == HOLD) && w_last) begin
            r_seq <= r_seq + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_mem2hexserial.sv
// tb/tb_mem2hexserial.sv - scoreboard bench for mem2hexserial (upper- and lowercase instances)
module tb_mem2hexserial;

`ifdef MEM2HEXSERIAL_SEQ_EN
    localparam int LINE = 17;
`else
    localparam int LINE = 14;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        uart_ready = 1'b1;

    logic        read_empty = 1'b1;
    logic        rce;
    logic [47:0] read_data = '0;
    logic        uce;
    logic [7:0]  uart_data;

    logic        lc_empty = 1'b1;
    logic        lc_rce;
    logic [47:0] lc_data = '0;
    logic        lc_uce;
    logic [7:0]  lc_uart_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [47:0] lc_fifo_q[$];
    logic [7:0]  lc_exp_q[$];
    int          strobes = 0, pops = 0, lc_strobes = 0, lc_pops = 0;
    int          tb_seq = 0, lc_seq = 0;
    bit          in_flight = 1'b0;

    always #5 clock = ~clock;

    mem2hexserial #(.DW(48), .UPPERCASE(1'b1)) dut (
        .clock             (clock),
        .reset             (reset),
        .read_empty        (read_empty),
        .read_clock_enable (rce),
        .read_data         (read_data),
        .uart_ready        (uart_ready),
        .uart_clock_enable (uce),
        .uart_data         (uart_data)
    );

    mem2hexserial #(.DW(48), .UPPERCASE(1'b0)) dut_lc (
        .clock             (clock),
        .reset             (reset),
        .read_empty        (lc_empty),
        .read_clock_enable (lc_rce),
        .read_data         (lc_data),
        .uart_ready        (uart_ready),
        .uart_clock_enable (lc_uce),
        .uart_data         (lc_uart_data)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n, input bit upper);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (upper ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    task automatic push_word(input logic [47:0] w);
        logic [7:0] s;
        s = tb_seq[7:0];
`ifdef MEM2HEXSERIAL_SEQ_EN
        exp_q.push_back(hexc(s[7:4], 1'b1));
        exp_q.push_back(hexc(s[3:0], 1'b1));
        exp_q.push_back(8'h20);
`endif
        tb_seq = (tb_seq + 1) % 256;
        for (int k = 0; k < 12; k++) exp_q.push_back(hexc(w[47-4*k -: 4], 1'b1));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        fifo_q.push_back(w);
    endtask

    task automatic lc_push_word(input logic [47:0] w);
        logic [7:0] s;
        s = lc_seq[7:0];
`ifdef MEM2HEXSERIAL_SEQ_EN
        lc_exp_q.push_back(hexc(s[7:4], 1'b0));
        lc_exp_q.push_back(hexc(s[3:0], 1'b0));
        lc_exp_q.push_back(8'h20);
`endif
        lc_seq = (lc_seq + 1) % 256;
        for (int k = 0; k < 12; k++) lc_exp_q.push_back(hexc(w[47-4*k -: 4], 1'b0));
        lc_exp_q.push_back(8'h0D);
        lc_exp_q.push_back(8'h0A);
        lc_fifo_q.push_back(w);
    endtask

    // Ring buffer model and output scoreboard for the uppercase instance.
    always @(negedge clock) begin
        if (rce) begin
            check_eq("pop_not_empty", 64'(fifo_q.size() != 0), 64'd1);
            check_eq("pop_one_in_flight", 64'(in_flight), 64'd0);
            pops++;
            in_flight = 1'b1;
            if (fifo_q.size() != 0) read_data = fifo_q.pop_front();
        end
        if (uce) begin
            logic [7:0] e;
            strobes++;
            check_eq("strobe_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("byte", 64'(uart_data), 64'(e));
                if (e == 8'h0A) in_flight = 1'b0;
            end
        end
        read_empty = (fifo_q.size() == 0);
    end

    // Ring buffer model and output scoreboard for the lowercase instance.
    always @(negedge clock) begin
        if (lc_rce) begin
            check_eq("lc_pop_not_empty", 64'(lc_fifo_q.size() != 0), 64'd1);
            lc_pops++;
            if (lc_fifo_q.size() != 0) lc_data = lc_fifo_q.pop_front();
        end
        if (lc_uce) begin
            lc_strobes++;
            check_eq("lc_strobe_expected", 64'(lc_exp_q.size() != 0), 64'd1);
            if (lc_exp_q.size() != 0) check_eq("lc_byte", 64'(lc_uart_data), 64'(lc_exp_q.pop_front()));
        end
        lc_empty = (lc_fifo_q.size() == 0);
    end

    task automatic drain(input int budget, input bit rnd_ready);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && lc_exp_q.size() == 0) break;
            @(posedge clock);
            #1;
            if (rnd_ready) uart_ready = 1'($urandom_range(0, 1));
        end
        check_eq("drain_done", 64'(exp_q.size() + lc_exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
        uart_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
    endtask

    initial begin
        int s0, p0;
        logic [7:0] snap;
        bit stable;

        repeat (2) @(posedge clock);
        #1;
        check_eq("reset_rce", 64'(rce), 64'd0);
        check_eq("reset_uce", 64'(uce), 64'd0);
        check_eq("reset_data", 64'(uart_data), 64'd0);
        check_eq("reset_lc_data", 64'(lc_uart_data), 64'd0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Single record, ready always high.
        push_word(48'h0123456789AB);
        drain(200, 1'b0);
        check_eq("line1_strobes", 64'(strobes), 64'(LINE));
        check_eq("line1_pops", 64'(pops), 64'd1);

        // Lowercase rendering.
        lc_push_word(48'hDEADBEEFCAFE);
        drain(200, 1'b0);
        check_eq("lc_strobes", 64'(lc_strobes), 64'(LINE));
        check_eq("lc_pops", 64'(lc_pops), 64'd1);

        // Two records back to back.
        s0 = strobes; p0 = pops;
        push_word(48'hFEDCBA987654);
        push_word(48'h00000000000F);
        drain(400, 1'b0);
        check_eq("two_strobes", 64'(strobes - s0), 64'(2 * LINE));
        check_eq("two_pops", 64'(pops - p0), 64'd2);

        // uart_ready held low: no strobes, data stable, then completes.
        uart_ready = 1'b0;
        s0 = strobes;
        push_word(48'hA5A5A5A55A5A);
        repeat (5) @(posedge clock);
        #1;
        snap = uart_data;
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            if (uart_data !== snap) stable = 1'b0;
        end
        check_eq("stall_strobes", 64'(strobes - s0), 64'd0);
        check_eq("stall_data_stable", 64'(stable), 64'd1);
        uart_ready = 1'b1;
        drain(200, 1'b0);
        check_eq("stall_release_strobes", 64'(strobes - s0), 64'(LINE));

        // Reset after the 5th byte of a line.
        s0 = strobes;
        push_word(48'h13579BDF2468);
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #2;
            if (strobes - s0 >= 5) break;
        end
        check_eq("reset_setup_bytes", 64'(strobes - s0), 64'd5);
        reset = 1'b0;
        #1;
        check_eq("midreset_rce", 64'(rce), 64'd0);
        check_eq("midreset_uce", 64'(uce), 64'd0);
        check_eq("midreset_data", 64'(uart_data), 64'd0);
        fifo_q.delete();
        exp_q.delete();
        in_flight = 1'b0;
        tb_seq = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        s0 = strobes; p0 = pops;
        repeat (50) @(posedge clock);
        #1;
        check_eq("post_reset_strobes", 64'(strobes - s0), 64'd0);
        check_eq("post_reset_pops", 64'(pops - p0), 64'd0);

        // Randomised ready with random records.
        s0 = strobes;
        for (int i = 0; i < 20; i++) push_word({$urandom, $urandom_range(0, 65535)} & 48'hFFFF_FFFF_FFFF);
        drain(20 * LINE * 8, 1'b1);
        check_eq("random_strobes", 64'(strobes - s0), 64'(20 * LINE));

        // 257 records: sequence prefix wraps back to 00 when enabled.
        tb_seq = 20;
        s0 = strobes;
        for (int i = 0; i < 257; i++) push_word({16'(i), 32'(i * 32'h9E37_79B9)});
        drain(257 * (LINE * 2 + 6), 1'b0);
        check_eq("bulk_strobes", 64'(strobes - s0), 64'(257 * LINE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
